// File: rtl/halflife_tick_gen_if.sv
// Control and status bundle between the half-life timebase and its user.
// All inputs are levels sampled on each rising clk edge; outputs are registered.
interface halflife_tick_gen_if #(
  parameter int PERIOD_W = 8
);
  logic                load_en;
  logic [PERIOD_W-1:0] period_in;
  logic                start;
  logic                stop;
  logic                tick;
  logic                running;
  logic [PERIOD_W-1:0] remaining;
  logic [3:0]          periods_elapsed;

  modport master (
    output load_en, period_in, start, stop,
    input  tick, running, remaining, periods_elapsed
  );

  modport slave (
    input  load_en, period_in, start, stop,
    output tick, running, remaining, periods_elapsed
  );
endinterface

// File: rtl/halflife_tick_gen.sv
// Timebase for the half-life timer: prescales clk into base units and pulses tick
// once per programmable period; supports pause/resume and clear-from-pause.
module halflife_tick_gen #(
  parameter int PRESCALE_DIV   = 1000,
  parameter int PERIOD_W       = 8,
  parameter int DEFAULT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  halflife_tick_gen_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int                PS_W    = $clog2(PRESCALE_DIV);
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PS_W-1:0]     prescale_q, prescale_d;
  logic [PERIOD_W-1:0] remaining_q, remaining_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [3:0]          pe_q, pe_d;
  logic                tick_q, tick_d;
  logic                running_q, running_d;
  logic                advance;

  always_comb begin
    state_d     = state_q;
    prescale_d  = prescale_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    pe_d        = pe_q;
    tick_d      = 1'b0;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.stop && bus.start && (period_q != '0)) begin
          state_d     = ST_RUN;
          remaining_d = period_q;
          prescale_d  = '0;
          pe_d        = 4'd0;
        end
      end
      ST_RUN: begin
        if (bus.stop) state_d = ST_PAUSED;
        else          advance = 1'b1;
      end
      ST_PAUSED: begin
        if (bus.stop) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          prescale_d  = '0;
        end else if (bus.start) begin
          // The resume edge is itself a counting edge.
          state_d = ST_RUN;
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (prescale_q == PS_LAST) begin
        prescale_d = '0;
        if (remaining_q > PERIOD_W'(1)) begin
          remaining_d = remaining_q - PERIOD_W'(1);
        end else begin
          // Reload reads the old period_reg even if load_en is high on this edge.
          tick_d      = 1'b1;
          remaining_d = (period_q == '0) ? PERIOD_W'(1) : period_q;
          if (pe_q != 4'd15) pe_d = pe_q + 4'd1;
        end
      end else begin
        prescale_d = prescale_q + PS_W'(1);
      end
    end

    if (bus.load_en) period_d = bus.period_in;
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prescale_q  <= '0;
      remaining_q <= '0;
      period_q    <= PERIOD_W'(DEFAULT_PERIOD);
      pe_q        <= 4'd0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      pe_q        <= pe_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
    end
  end

  assign bus.tick            = tick_q;
  assign bus.running         = running_q;
  assign bus.remaining       = remaining_q;
  assign bus.periods_elapsed = pe_q;
  assign dbg_state           = state_q;
endmodule

// File: tb/tb_halflife_tick_gen.sv
// Bench for halflife_tick_gen: directed scenarios plus random control traffic,
// checked every cycle against an edge-count reference model.
module tb_halflife_tick_gen;
  localparam int DIV = 4;
  localparam int PW  = 8;
  localparam int W   = 2 + PW + 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  halflife_tick_gen_if #(.PERIOD_W(PW)) bus ();
  logic [1:0] dbg_state;

  halflife_tick_gen #(
    .PRESCALE_DIV  (DIV),
    .PERIOD_W      (PW),
    .DEFAULT_PERIOD(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: a period is m_plen*DIV counting edges; remaining is derived.
  int m_st;    // 0 idle, 1 run, 2 paused
  int m_cnt;
  int m_plen;
  int m_preg;
  int m_pe;
  bit m_tick;

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_plen = 0; m_preg = 8; m_pe = 0; m_tick = 1'b0;
  endtask

  function automatic logic [W-1:0] m_expect();
    int rem;
    rem = (m_st == 0) ? 0 : m_plen - m_cnt / DIV;
    return {m_tick, (m_st == 1), PW'(rem), 4'(m_pe)};
  endfunction

  task automatic m_advance();
    m_cnt++;
    if (m_cnt == m_plen * DIV) begin
      m_tick = 1'b1;
      m_cnt  = 0;
      m_plen = (m_preg == 0) ? 1 : m_preg;
      if (m_pe < 15) m_pe++;
    end
  endtask

  task automatic m_edge(bit s, bit p, bit ld, int pin);
    m_tick = 1'b0;
    case (m_st)
      0: if (!p && s && m_preg != 0) begin
           m_st = 1; m_plen = m_preg; m_cnt = 0; m_pe = 0;
         end
      1: if (p) m_st = 2; else m_advance();
      default: if (p) begin
                 m_st = 0; m_cnt = 0;
               end else if (s) begin
                 m_st = 1; m_advance();
               end
    endcase
    if (ld) m_preg = pin;
  endtask

  // scoreboard
  task automatic check(string tag);
    logic [W-1:0] exp, got;
    exp = exp_q.pop_front();
    got = {bus.tick, bus.running, bus.remaining, bus.periods_elapsed};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got(tick,run,rem,pe)=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_val(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // driver
  task automatic step(string tag, bit s, bit p, bit ld = 1'b0, int pin = 0);
    @(negedge clk);
    bus.start     = s;
    bus.stop      = p;
    bus.load_en   = ld;
    bus.period_in = PW'(pin);
    @(posedge clk);
    cyc++;
    m_edge(s, p, ld, pin);
    exp_q.push_back(m_expect());
    #1 check(tag);
  endtask

  task automatic idle_n(string tag, int n);
    repeat (n) step(tag, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.load_en = 1'b0; bus.period_in = '0;
    rst = 1'b1;
    m_reset();
    #1;
    exp_q.push_back(m_expect());
    check("t1_reset_no_edge");
    @(negedge clk) rst = 1'b0;

    // default period 8 -> first tick 32 edges after start
    step("t1_start", 1'b1, 1'b0);
    idle_n("t1_run", 34);

    // period 3: ticks after E12 and E24
    step("t2_stop", 1'b0, 1'b1);
    step("t2_clear", 1'b0, 1'b1);
    step("t2_load", 1'b0, 1'b0, 1'b1, 3);
    step("t2_start", 1'b1, 1'b0);
    idle_n("t2_run", 25);
    expect_val("t2_pe", int'(bus.periods_elapsed), 2);

    // pause with frozen remaining, then resume
    step("t3_stop", 1'b0, 1'b1);
    step("t3_clear", 1'b0, 1'b1);
    step("t3_start", 1'b1, 1'b0);
    idle_n("t3_run", 5);
    step("t3_pause", 1'b0, 1'b1);
    idle_n("t3_hold", 10);
    expect_val("t3_frozen_rem", int'(bus.remaining), 2);
    step("t3_resume", 1'b1, 1'b0);
    idle_n("t3_run2", 8);

    // period 1: tick every 4 cycles, pe saturates at 15
    step("t4_stop", 1'b0, 1'b1);
    step("t4_clear", 1'b0, 1'b1);
    step("t4_load", 1'b0, 1'b0, 1'b1, 1);
    step("t4_start", 1'b1, 1'b0);
    idle_n("t4_run", 84);
    expect_val("t4_pe_sat", int'(bus.periods_elapsed), 15);

    // period 0 start ignored; start+stop in IDLE; load mid-run
    step("t5_stop", 1'b0, 1'b1);
    step("t5_clear", 1'b0, 1'b1);
    step("t5_load0", 1'b0, 1'b0, 1'b1, 0);
    repeat (3) step("t5_start0", 1'b1, 1'b0);
    step("t5_load3", 1'b0, 1'b0, 1'b1, 3);
    step("t5_start_stop", 1'b1, 1'b1);
    step("t5_start", 1'b1, 1'b0);
    idle_n("t5_run", 5);
    step("t5_load5", 1'b0, 1'b0, 1'b1, 5);
    idle_n("t5_run2", 30);

    // async reset between edges
    #2 rst = 1'b1;
    #1;
    m_reset();
    exp_q.push_back(m_expect());
    check("t6_async_rst");
    expect_val("t6_state", int'(dbg_state), 0);
    @(negedge clk) rst = 1'b0;

    // stop twice keeps periods_elapsed
    step("t6_load1", 1'b0, 1'b0, 1'b1, 1);
    step("t6_start", 1'b1, 1'b0);
    idle_n("t6_run", 10);
    step("t6_pause", 1'b0, 1'b1);
    step("t6_clear", 1'b0, 1'b1);
    expect_val("t6_pe_held", int'(bus.periods_elapsed), 2);
    expect_val("t6_rem_zero", int'(bus.remaining), 0);
    idle_n("t6_idle", 3);

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      step("t7_rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
